write_ptr_full_ctrl: RTL

//  Write-domain pointer/flag generator of the async FIFO; sits directly upstream of sync_addr_gray.
//  - Owns the write pointer and converts each accepted write into a memory address plus a

---
 rtl/fifo_ptr_pkg.sv | 49 ++++
 rtl/write_ptr_full_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared definitions for the async FIFO pointer controllers (write-side full
// controller and read-side empty controller).
//
// Contents
//   DEF_FIFO_DEPTH_BIT / DEF_FIFO_DEPTH / DEF_ALMOST_FULL_GAP
//                 : default geometry used by both pointer controllers
//   PTR_W         : pointer width for the default geometry (address + wrap bit)
//   GRAY_MAX_W    : widest pointer the conversion helpers handle
//   bin2gray()    : binary -> reflected Gray
//   gray2bin()    : reflected Gray -> binary
//
// The helpers work on a GRAY_MAX_W-bit operand. Callers zero-extend a narrower
// pointer and cast the result back down. Leading zeros do not change the
// conversion in either direction, so one pair of functions serves every
// pointer width up to GRAY_MAX_W.
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

  localparam int DEF_FIFO_DEPTH_BIT  = 4;
  localparam int DEF_FIFO_DEPTH      = 2 ** DEF_FIFO_DEPTH_BIT;
  localparam int DEF_ALMOST_FULL_GAP = 2;
  localparam int PTR_W               = DEF_FIFO_DEPTH_BIT + 1;

  localparam int GRAY_MAX_W = 32;

  // Adjacent codes differ in exactly one bit. That property makes a
  // multi-bit pointer safe to pass through a bit-wise synchroniser.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(
    input logic [GRAY_MAX_W-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it. The loop
  // walks from the MSB down and carries a running parity.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(
    input logic [GRAY_MAX_W-1:0] gray
  );
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : fifo_ptr_pkg

// File: rtl/write_ptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// write_ptr_full_ctrl
// Write-domain pointer and flag generator of the async FIFO. It sits directly
// upstream of sync_addr_gray.
//
// The block owns the binary write pointer. Every accepted write produces a RAM
// address and advances a registered Gray copy of the pointer, which
// sync_addr_gray carries into the read clock domain. The read pointer arrives
// here already synchronised into w_clk, as Gray. This block uses it to derive
// full, almost_full, a write-side occupancy estimate and a sticky overflow
// flag.
//
// The synchronised read pointer lags the true read pointer by the synchroniser
// delay. Every flag here is therefore pessimistic: full and the level clear
// late, never early.
//
// Parameters
//   FIFO_DEPTH       number of entries, must equal 2**FIFO_DEPTH_BIT
//   FIFO_DEPTH_BIT   address width N; pointers carry N+1 bits (extra wrap bit)
//   ALMOST_FULL_GAP  almost_full asserts at level >= FIFO_DEPTH-ALMOST_FULL_GAP
//
// Ports
//   w_clk                in   1    write clock, the only clock of the block
//   w_rst                in   1    synchronous active-low reset
//   write_en             in   1    write request from the producer
//   read_addr_gray_sync  in   N+1  read pointer (Gray), synchronised to w_clk
//   ovf_clr              in   1    clears the sticky overflow flag
//   mem_write_en         out  1    RAM write strobe = write_en & ~full (comb.)
//   write_addr           out  N    RAM write address (binary pointer [N-1:0])
//   write_addr_gray      out  N+1  registered Gray write pointer
//   full                 out  1    registered full flag
//   almost_full          out  1    registered almost-full flag
//   wr_level             out  N+1  registered occupancy estimate, 0..FIFO_DEPTH
//   overflow             out  1    sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module write_ptr_full_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int FIFO_DEPTH_BIT  = DEF_FIFO_DEPTH_BIT,
  parameter int ALMOST_FULL_GAP = DEF_ALMOST_FULL_GAP
) (
  input  logic                    w_clk,
  input  logic                    w_rst,
  input  logic                    write_en,
  input  logic [FIFO_DEPTH_BIT:0] read_addr_gray_sync,
  input  logic                    ovf_clr,
  output logic                    mem_write_en,
  output logic [FIFO_DEPTH_BIT-1:0] write_addr,
  output logic [FIFO_DEPTH_BIT:0] write_addr_gray,
  output logic                    full,
  output logic                    almost_full,
  output logic [FIFO_DEPTH_BIT:0] wr_level,
  output logic                    overflow
);

  localparam int W = FIFO_DEPTH_BIT + 1;   // pointer width incl. wrap bit

  // Threshold held at pointer width so the compare stays W bits wide.
  localparam logic [W-1:0] AF_THRESH = W'(FIFO_DEPTH - ALMOST_FULL_GAP);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0] bin_q,   bin_d;
  logic [W-1:0] gray_q,  gray_d;
  logic [W-1:0] level_q, level_d;
  logic         full_q,  full_d;
  logic         afull_q, afull_d;
  logic         ovf_q,   ovf_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic         w_inc;
  logic [W-1:0] rbin;
  logic [W-1:0] full_pattern;

  // Holding reset low masks the strobe as well as the pointer update, so the
  // RAM sees no write while the block is in reset.
  assign w_inc = write_en & ~full_q & w_rst;

  // Read pointer converted to binary for the level arithmetic.
  assign rbin = W'(gray2bin(GRAY_MAX_W'(read_addr_gray_sync)));

  // When the FIFO is full, the write pointer sits exactly FIFO_DEPTH ahead of
  // the read pointer. In Gray code that is the read pointer with its two MSBs
  // inverted and the remaining bits equal. The Gray form is compared directly,
  // so no conversion sits in the full path.
  assign full_pattern = {~read_addr_gray_sync[W-1:W-2],
                         read_addr_gray_sync[W-3:0]};

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves it unassigned and no latch can be inferred.
  always_comb begin
    bin_d   = bin_q + W'(w_inc);          // natural wrap 2**W-1 -> 0
    gray_d  = W'(bin2gray(GRAY_MAX_W'(bin_d)));
    full_d  = (gray_d == full_pattern);
    level_d = bin_d - rbin;               // modular subtract, wrap-safe
    afull_d = (level_d >= AF_THRESH);

    // A new overflow event wins over a clear in the same cycle.
    ovf_d = ovf_q;
    if (write_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its inputs, whatever the block order.
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_write_en    = w_inc;
  assign write_addr      = bin_q[W-2:0];
  assign write_addr_gray = gray_q;
  assign full            = full_q;
  assign almost_full     = afull_q;
  assign wr_level        = level_q;
  assign overflow        = ovf_q;

endmodule : write_ptr_full_ctrl
